// File: rtl/cnu_sched.sv
// Row scheduler for the layered LDPC check-node array: issues row reads, CNU enables and
// LAT-delayed write-backs once per iteration, and stops on parity success or iteration limit.
module cnu_sched #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned ROW_W  = 3,
    parameter int unsigned ITER_W = 5,
    parameter int unsigned LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              stall,
    input  logic              parity_ok,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              cnu_en,
    output logic              chk_clr,
    output logic              rd_en,
    output logic [ROW_W-1:0]  rd_addr,
    output logic              wr_en,
    output logic [ROW_W-1:0]  wr_addr
);

    typedef enum logic [2:0] {StIdle, StIssue, StDrain, StCheck, StDone} state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] max_q, max_d;
    logic              conv_q, conv_d;

    // Write-back delay line: one {valid, addr} entry per cycle of read-to-result latency.
    logic [LAT-1:0]    pv_q;
    logic [ROW_W-1:0]  pa_q [LAT];
    logic              pipe_pending;

    // Anything still in front of the last stage means DRAIN is not finished yet.
    always_comb begin
        pipe_pending = 1'b0;
        for (int i = 0; i < int'(LAT) - 1; i++) begin
            pipe_pending = pipe_pending | pv_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        iter_d  = iter_q;
        max_d   = max_q;
        conv_d  = conv_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    max_d   = (max_iter == '0) ? ITER_W'(1) : max_iter;
                    iter_d  = '0;
                    conv_d  = 1'b0;
                    row_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!stall) begin
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = StDrain;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            StDrain: begin
                if (!stall && !pipe_pending) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                iter_d = iter_q + ITER_W'(1);
                if (parity_ok) begin
                    conv_d  = 1'b1;
                    state_d = StDone;
                end else if ((iter_q + ITER_W'(1)) == max_q) begin
                    conv_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    row_d   = '0;
                    state_d = StIssue;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            iter_q  <= '0;
            max_q   <= ITER_W'(1);
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            iter_q  <= iter_d;
            max_q   <= max_d;
            conv_q  <= conv_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                pa_q[i] <= '0;
            end
        end else if (!stall) begin
            for (int i = int'(LAT) - 1; i > 0; i--) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
            pv_q[0] <= rd_en;
            pa_q[0] <= row_q;
        end
    end

    assign rd_en     = (state_q == StIssue) && !stall;
    assign rd_addr   = row_q;
    assign chk_clr   = rd_en && (row_q == '0);
    assign wr_en     = pv_q[LAT-1] && !stall;
    assign wr_addr   = pa_q[LAT-1];
    assign cnu_en    = !stall && ((state_q == StIssue) || (state_q == StDrain));
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign converged = conv_q;
    assign iter_cnt  = iter_q;

endmodule

// File: doc/cnu_sched.md
# cnu_sched

Row scheduler for the check-node unit array of the layered LDPC decoder. It sequences all check rows of the code through the CNU pipeline once per iteration, issuing message-memory reads, the CNU enable and delayed write-backs. It counts iterations and stops on parity success or on the iteration limit. It sits between the decoder top-level control (start/done) and the message memory plus CNU bank.

## Interface
- ROWS, default 8: check rows per iteration (≥2).
- ROW_W, default 3: row address width, 2^ROW_W ≥ ROWS.
- ITER_W, default 5: iteration counter width.
- LAT, default 2: cycles from a row's read issue to its CNU result being writable (≥1).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin decoding; honoured only in IDLE.
- max_iter  in  ITER_W  iteration limit, sampled on accepted start; 0 treated as 1.
- stall  in  1  memory back-pressure; freezes the whole block while high.
- parity_ok  in  1  syndrome-check result, sampled in CHECK.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- converged  out  1  result of the last run (1 = parity satisfied).
- iter_cnt  out  ITER_W  iterations completed in the current or last run.
- cnu_en  out  1  CNU register enable.
- chk_clr  out  1  clear for the external parity accumulator.
- rd_en  out  1  message-memory read strobe.
- rd_addr  out  ROW_W  row being read.
- wr_en  out  1  write-back strobe.
- wr_addr  out  ROW_W  row being written.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, CHECK, DONE.
- IDLE, start=1: latch max_iter (0→1), clear iter_cnt, converged and row counter. Next state is ISSUE.
- ISSUE: rd_en=!stall and rd_addr=row counter. The counter increments when !stall. After row ROWS-1 is issued, the next state is DRAIN.
- chk_clr = rd_en & (rd_addr==0).
- Write pipeline: LAT-stage shift register of {valid, addr}, shifting only when !stall. Stage 0 loads {rd_en, rd_addr}.
- wr_en = last-stage valid & !stall. wr_addr = last-stage addr.
- DRAIN: no reads. Lasts until the pipeline is empty after the final write, i.e. LAT non-stalled cycles. Next state is CHECK.
- CHECK (1 cycle, no stall effect): iter_cnt increments. Then:
  - parity_ok=1 → converged=1, go to DONE.
  - else if iter_cnt+1 == max_iter → converged=0, go to DONE.
  - else reset the row counter and go to ISSUE.
- DONE: done=1 for one cycle, then IDLE. iter_cnt and converged hold until the next accepted start.
- cnu_en = !stall & (ISSUE | DRAIN).
- rd_en, wr_en, cnu_en and chk_clr are combinational from state/pipeline and stall. All other outputs are registered.
- start while busy is ignored, with no effect on state or counters.
- Reset mid-run: immediate return to IDLE, pipeline cleared, no done pulse.
- Reset values: busy=0, done=0, converged=0, iter_cnt=0, all strobes 0, rd_addr=0, wr_addr=0, state IDLE.

## Timing
- start sampled at edge 0. The first read (row 0, with chk_clr) is in cycle 1.
- Row r is read in cycle 1+r and written in cycle 1+r+LAT, with no stall.
- Per iteration: ROWS ISSUE cycles + LAT DRAIN cycles + 1 CHECK cycle.
- A following iteration's row 0 read comes in the cycle after CHECK.
- done pulses in cycle N·(ROWS+LAT+1)+1 for N iterations, with no stall.
- Each stall cycle delays every subsequent event by exactly one cycle. No read or write is lost or duplicated.
- Reads and writes overlap: in ISSUE, rd_en and wr_en may both be high with different rows.

## Test plan
- ROWS=8, LAT=2, max_iter=1, parity_ok=0, no stall:
  - reads rows 0..7 in cycles 1..8; writes rows 0..7 in cycles 3..10.
  - CHECK at 11, done at 12; converged=0, iter_cnt=1.
- max_iter=5, parity_ok raised during the 3rd iteration's CHECK:
  - done at cycle 3·11+1=34; converged=1, iter_cnt=3.
  - chk_clr pulses exactly 3 times.
- max_iter=4, parity_ok=0:
  - exactly 4 iterations (32 reads, 32 writes); done at 45; converged=0.
- stall held high for cycles 4–6 in iteration 1:
  - rd_addr and the pipeline freeze; cnu_en, rd_en and wr_en are low.
  - The read/write sequence is unchanged; done is delayed by 3 cycles, to 15.
- Pulse start at cycles 5 and 12 during a 1-iteration run: ignored, and done still occurs once at 12. max_iter=0 behaves as 1 iteration.
- Assert rst_n low at cycle 6 of a run:
  - all outputs go to reset values immediately; no done pulse.
  - A new start after release gives the first read at the following cycle.
